// File: rtl/matrix_scroll_sequencer.sv
// Scroll sequencer for a digit matrix: buffers digit commands in a 4-deep FIFO and walks
// each digit through eight shifted frames, handshaking every frame with the strip serializer.
//
// state  | meaning
// IDLE   | nothing to show; waits for a buffered digit
// START  | one-clock frame_start pulse to the serializer
// WAIT   | waiting for frame_done, bounded by DONE_TIMEOUT clocks
// GAP    | GAP_CYCLES idle clocks, then next shift or next digit
module matrix_scroll_sequencer #(
  parameter int GAP_CYCLES   = 1000,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_digit,
  output logic       cmd_ready,
  output logic       frame_start,
  input  logic       frame_done,
  output logic [3:0] cur_digit,
  output logic [3:0] nxt_digit,
  output logic [2:0] shift,
  output logic       first,
  output logic       idle,
  output logic       timeout_err
);

  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [3:0]      r_fifo [4];
  logic [1:0]      r_wr_ptr;
  logic [1:0]      r_rd_ptr;
  logic [2:0]      r_count;
  logic [2:0]      w_count_nxt;
  logic            r_cmd_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_ne;

  logic [3:0]      r_cur;
  logic [3:0]      r_nxt;
  logic [2:0]      r_shift;
  logic            r_first;
  logic            r_timeout_err;
  logic [TW-1:0]   r_to_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_to_hit;
  logic            w_gap_hit;
  logic            w_shift_inc;
  logic            w_roll;
  logic            w_set_err;

  assign w_fifo_ne = (r_count != 3'd0);
  assign w_push    = cmd_valid & r_cmd_ready;
  assign w_to_hit  = (r_to_cnt == TO_LAST);
  assign w_gap_hit = (r_gap_cnt == GAP_LAST);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= cmd_digit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != 3'd4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift_inc = 1'b0;
    w_roll      = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (frame_done) begin
          w_state_nxt = S_GAP;
        end else if (w_to_hit) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_hit) begin
          if (r_shift != 3'd7) begin
            w_shift_inc = 1'b1;
            w_state_nxt = S_START;
          end else begin
            // Digit fully scrolled in; chain straight into the next one if buffered.
            w_roll = 1'b1;
            if (w_fifo_ne) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_state == S_START) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_WAIT) && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if ((r_state != S_GAP) || w_gap_hit) begin
        r_gap_cnt <= '0;
      end else begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur         <= '0;
      r_nxt         <= '0;
      r_shift       <= '0;
      r_first       <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_nxt <= r_fifo[r_rd_ptr];
      end
      if (w_roll) begin
        r_cur   <= r_nxt;
        r_first <= 1'b0;
      end
      if (w_roll || w_pop) begin
        r_shift <= '0;
      end else if (w_shift_inc) begin
        r_shift <= r_shift + 3'd1;
      end
      if (w_set_err) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign frame_start = (r_state == S_START);
  assign idle        = (r_state == S_IDLE);
  assign cur_digit   = r_cur;
  assign nxt_digit   = r_nxt;
  assign shift       = r_shift;
  assign first       = r_first;
  assign timeout_err = r_timeout_err;

endmodule
